// File: rtl/lcd_driver_n_if.sv
// Bus bundle between the watch core (master) and the N-digit LCD driver (slave).
// Carries time/key sources, display selects, alarm controls and the LCD outputs.
interface lcd_driver_n_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
);
  logic [NUM_DIGITS*DIGIT_W-1:0] alarm_time;
  logic [NUM_DIGITS*DIGIT_W-1:0] current_time;
  logic [NUM_DIGITS*DIGIT_W-1:0] key;
  logic                          show_alarm;
  logic                          show_new_time;
  logic                          alarm_en;
  logic                          alarm_off;
  logic [NUM_DIGITS*8-1:0]       display_time;
  logic                          sound_alarm;

  modport master (
    output alarm_time, current_time, key,
    output show_alarm, show_new_time, alarm_en, alarm_off,
    input  display_time, sound_alarm
  );

  modport slave (
    input  alarm_time, current_time, key,
    input  show_alarm, show_new_time, alarm_en, alarm_off,
    output display_time, sound_alarm
  );
endinterface

// File: rtl/lcd_driver_n.sv
// N-digit BCD-to-LCD driver with flashing key entry and a latched, self-timing alarm.
// Optional LCD_LEADING_ZERO_BLANK_EN blanks a zero in the most-significant hour digit.
module lcd_driver_n #(
  parameter int NUM_DIGITS    = 4,
  parameter int DIGIT_W       = 4,
  parameter int FLASH_HALF    = 256,
  parameter int ALARM_TIMEOUT = 1024
) (
  input  logic           clock,
  input  logic           reset_n,
  lcd_driver_n_if.slave  bus
);

  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam int TW = (ALARM_TIMEOUT > 0) ? $clog2(ALARM_TIMEOUT + 1) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
  localparam logic [TW-1:0] TO_LAST    = (ALARM_TIMEOUT > 0) ? TW'(ALARM_TIMEOUT - 1) : '0;
  localparam int MSD = NUM_DIGITS - 1;

  function automatic logic [7:0] encode_digit(input logic [DIGIT_W-1:0] v);
    if (v > DIGIT_W'(9)) begin
      encode_digit = 8'h21;
    end else begin
      encode_digit = 8'h30 + 8'(v);
    end
  endfunction

  logic [NUM_DIGITS*DIGIT_W-1:0] sel_time_s;
  logic [NUM_DIGITS*8-1:0]       display_s;
  logic [NUM_DIGITS*8-1:0]       display_r;
  logic [FW-1:0]                 blink_cnt_r;
  logic                          blink_phase_r;
  logic [TW-1:0]                 timeout_cnt_r;
  logic                          match_q_r;
  logic                          sound_r;
  logic                          entry_s;
  logic                          blank_s;
  logic                          lead_zero_s;
  logic                          match_s;
  logic                          rise_s;
  logic                          timeout_s;
  logic                          clear_s;

  assign entry_s   = bus.show_new_time & ~bus.show_alarm;
  assign blank_s   = entry_s & ~blink_phase_r;
  assign match_s   = bus.alarm_en & (bus.alarm_time == bus.current_time);
  assign rise_s    = match_s & ~match_q_r;
  assign timeout_s = (ALARM_TIMEOUT != 0) && sound_r && (timeout_cnt_r == TO_LAST);
  // Clear wins over a simultaneous rising edge, so alarm_off can veto a fresh match.
  assign clear_s   = bus.alarm_off | ~bus.alarm_en | timeout_s;

  assign bus.display_time = display_r;
  assign bus.sound_alarm  = sound_r;

  // Source select: alarm view beats key entry beats running time.
  always_comb begin
    if (bus.show_alarm) begin
      sel_time_s = bus.alarm_time;
    end else if (bus.show_new_time) begin
      sel_time_s = bus.key;
    end else begin
      sel_time_s = bus.current_time;
    end
  end

  // Per-digit encode with flash blanking and optional leading-zero suppression.
  always_comb begin
    display_s = '0;
`ifdef LCD_LEADING_ZERO_BLANK_EN
    lead_zero_s = (sel_time_s[MSD*DIGIT_W +: DIGIT_W] == '0);
`else
    lead_zero_s = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (blank_s || ((i == MSD) && lead_zero_s)) begin
        display_s[i*8 +: 8] = 8'h20;
      end else begin
        display_s[i*8 +: 8] = encode_digit(sel_time_s[i*DIGIT_W +: DIGIT_W]);
      end
    end
  end

  // Display output register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      display_r <= {NUM_DIGITS{8'h20}};
    end else begin
      display_r <= display_s;
    end
  end

  // Blink timer: free-runs only during key entry, otherwise parked visible.
  always_ff @(posedge clock) begin
    if (!reset_n || !entry_s) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b1;
    end else if (blink_cnt_r == FLASH_LAST) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= ~blink_phase_r;
    end else begin
      blink_cnt_r   <= blink_cnt_r + FW'(1);
    end
  end

  // Alarm latch: set on match rising edge, timeout counter saturates while sounding.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      match_q_r     <= 1'b0;
      sound_r       <= 1'b0;
      timeout_cnt_r <= '0;
    end else begin
      match_q_r <= match_s;
      if (clear_s) begin
        sound_r       <= 1'b0;
        timeout_cnt_r <= '0;
      end else if (rise_s) begin
        sound_r       <= 1'b1;
        timeout_cnt_r <= '0;
      end else if (sound_r && (timeout_cnt_r != {TW{1'b1}})) begin
        timeout_cnt_r <= timeout_cnt_r + TW'(1);
      end else begin
        timeout_cnt_r <= timeout_cnt_r;
      end
    end
  end

endmodule
